// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One-hot result codes, ordered {eq, gt, lt}
  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  function automatic int unsigned num_digits(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  // Bits needed to index n digits; never less than one
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational compare of one DIGIT-bit slice; top_signed flips the slice MSB
// so a two's-complement top digit orders as offset binary.
module digit_cmp
  import serial_cmp_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             top_signed,
  output logic             dgt,
  output logic             dlt
);

  logic [DIGIT-1:0] am;
  logic [DIGIT-1:0] bm;

  always_comb begin
    am = a;
    bm = b;
    if (top_signed) begin
      am[DIGIT-1] = ~a[DIGIT-1];
      bm[DIGIT-1] = ~b[DIGIT-1];
    end
    dgt = (am > bm);
    dlt = (am < bm);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator, DIGIT bits per cycle, MSB digit first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing digit.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGIT  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT);
  localparam int unsigned IW = idx_width(N);
  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  state_t           state, next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [DIGIT-1:0] da, db;
  logic             dgt, dlt, top_signed, exit_now, last, resolved;
  logic [2:0]       run_res, final_res, res;

  assign da = DIGIT'(a_r >> (32'(idx) * DIGIT));
  assign db = DIGIT'(b_r >> (32'(idx) * DIGIT));
  assign top_signed = SIGNED && (idx == TOP_IDX);

  digit_cmp #(.DIGIT(DIGIT)) u_digit (
    .a          (da),
    .b          (db),
    .top_signed (top_signed),
    .dgt        (dgt),
    .dlt        (dlt)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign exit_now = dgt | dlt;
`else
  assign exit_now = 1'b0;
`endif

  assign last = (idx == '0) || exit_now;

  // The digit compared on the final edge counts unless an earlier one resolved
  always_comb begin
    final_res = EQ;
    if (resolved)  final_res = run_res;
    else if (dgt)  final_res = GT;
    else if (dlt)  final_res = LT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      resolved <= 1'b0;
      run_res  <= EQ;
      res      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            idx      <= TOP_IDX;
            resolved <= 1'b0;
            run_res  <= EQ;
          end
        end
        RUN: begin
          if (!resolved && (dgt || dlt)) begin
            resolved <= 1'b1;
            run_res  <= dgt ? GT : LT;
          end
          if (last) res <= final_res;
          else      idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign {eq, gt, lt} = res;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator (32/4, 4/4, 8/4 builds).
module tb_serial_mag_comparator;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;
  localparam logic [2:0] R_NONE = 3'b000;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start4, start8;
  logic [31:0] a32, b32;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  // index: 0=32u 1=32s 2=4u 3=4s 4=8u 5=8s
  logic [5:0]  busy, done, eq, gt, lt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(32), .DIGIT(4), .SIGNED(1'b0)) dut32u (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy[0]), .done(done[0]), .eq(eq[0]), .gt(gt[0]), .lt(lt[0]));
  serial_mag_comparator #(.WIDTH(32), .DIGIT(4), .SIGNED(1'b1)) dut32s (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy[1]), .done(done[1]), .eq(eq[1]), .gt(gt[1]), .lt(lt[1]));
  serial_mag_comparator #(.WIDTH(4), .DIGIT(4), .SIGNED(1'b0)) dut4u (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy[2]), .done(done[2]), .eq(eq[2]), .gt(gt[2]), .lt(lt[2]));
  serial_mag_comparator #(.WIDTH(4), .DIGIT(4), .SIGNED(1'b1)) dut4s (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy[3]), .done(done[3]), .eq(eq[3]), .gt(gt[3]), .lt(lt[3]));
  serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED(1'b0)) dut8u (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy[4]), .done(done[4]), .eq(eq[4]), .gt(gt[4]), .lt(lt[4]));
  serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED(1'b1)) dut8s (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy[5]), .done(done[5]), .eq(eq[5]), .gt(gt[5]), .lt(lt[5]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int i);
    return {eq[i], gt[i], lt[i]};
  endfunction

  function automatic logic [2:0] model(input int unsigned x, input int unsigned y,
                                       input int w, input bit sgn);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sgn && x[w-1]) sx = sx - (longint'(1) << w);
    if (sgn && y[w-1]) sy = sy - (longint'(1) << w);
    if (sx == sy) return R_EQ;
    return (sx > sy) ? R_GT : R_LT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a 32-bit compare and count edges until done, bounded
  task automatic go32(input logic [31:0] x, input logic [31:0] y, output int edges);
    a32 = x; b32 = y; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    edges = 0;
    while (!done[0] && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  // p = MSB-first index of first differing digit (7 for equal operands)
  task automatic cmp32(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input int p, input logic [2:0] exp_u, input logic [2:0] exp_s);
    int edges;
    go32(x, y, edges);
    chk({tag, "_lat"}, edges, EARLY ? p + 1 : 8);
    chk({tag, "_u"}, res_of(0), exp_u);
    chk({tag, "_s"}, res_of(1), exp_s);
    chk({tag, "_done_s"}, done[1], 1'b1);
    tick();
    chk({tag, "_pulse"}, {done[0], busy[0]}, 2'b00);
  endtask

  initial begin
    int n, edges, seen;
    logic [7:0] bb;
    rst = 1'b1;
    start32 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a32 = '0; b32 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 6'b0);
    chk("reset_done", done, 6'b0);
    chk("reset_res", {eq, gt, lt}, 18'b0);
    rst = 1'b0;
    tick();

    cmp32("lt_low", 32'h1234_5678, 32'h1234_5679, 7, R_LT, R_LT);
    cmp32("eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7, R_EQ, R_EQ);
    cmp32("msb", 32'h8000_0000, 32'h7FFF_FFFF, 0, R_GT, R_LT);
    cmp32("neg1", 32'h0000_0001, 32'hFFFF_FFFF, 0, R_LT, R_GT);
    cmp32("neg2", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 7, R_LT, R_LT);

    // Reset in the third RUN cycle clears everything and drops the compare
    a32 = 32'h0000_0001; b32 = 32'h0000_0002; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy[1:0], 2'b00);
    chk("mid_rst_done", done[1:0], 2'b00);
    chk("mid_rst_res_u", res_of(0), R_NONE);
    chk("mid_rst_res_s", res_of(1), R_NONE);
    #3 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done[0] || done[1]) seen++;
    end
    chk("mid_rst_nodone", seen, 0);

    // Results hold through a long idle stretch
    cmp32("hold", 32'h8000_0000, 32'h7FFF_FFFF, 0, R_GT, R_LT);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done[0]) seen++;
    end
    chk("hold_nodone", seen, 0);
    chk("hold_u", res_of(0), R_GT);
    chk("hold_s", res_of(1), R_LT);

    // start held high; operands churn after capture
    a32 = 32'h0000_0010; b32 = 32'h0000_0011; start32 = 1'b1;
    tick();
    edges = 0;
    while (!done[0] && edges < 40) begin
      a32 = $urandom; b32 = $urandom;
      tick();
      edges++;
    end
    chk("held_lat1", edges, 8);
    chk("held_res1", res_of(0), R_LT);
    a32 = $urandom; b32 = $urandom;
    tick();
    chk("held_idle", busy[0], 1'b0);
    a32 = 32'h5555_5555; b32 = 32'h5555_5555;
    tick();
    chk("held_accept", busy[0], 1'b1);
    start32 = 1'b0;
    edges = 0;
    while (!done[0] && edges < 40) begin
      a32 = $urandom; b32 = $urandom;
      tick();
      edges++;
    end
    chk("held_lat2", edges, 8);
    chk("held_res2", res_of(0), R_EQ);
    tick();

    // Exhaustive 4-bit sweep, single RUN cycle
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done[2] && n < 10) begin
          tick();
          n++;
        end
        chk("sw4_lat", n, 1);
        chk("sw4_u", res_of(2), model(i, j, 4, 1'b0));
        chk("sw4_s", res_of(3), model(i, j, 4, 1'b1));
        chk("sw4_onehot", {$onehot(res_of(2)), $onehot(res_of(3))}, 2'b11);
        tick();
      end
    end

    // 8-bit sweep: every a against boundary and near-equal b values
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 6; k++) begin
        case (k)
          0: bb = 8'h00;
          1: bb = 8'h7F;
          2: bb = 8'h80;
          3: bb = 8'hFF;
          4: bb = 8'(i);
          default: bb = 8'(i) ^ 8'h01;
        endcase
        a8 = 8'(i); b8 = bb; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done[4] && n < 10) begin
          tick();
          n++;
        end
        chk("sw8_u", res_of(4), model(i, bb, 8, 1'b0));
        chk("sw8_s", res_of(5), model(i, bb, 8, 1'b1));
        chk("sw8_onehot", {$onehot(res_of(4)), $onehot(res_of(5)), done[5]}, 3'b111);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
